instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage for the RISC-V core. Holds the program counter, reads 32-bit words from a synchronous-read instruction memory, and hands each word, with its PC and pre-sliced decode fields, to the control unit over a valid/ready handshake. A 2-entry buffer absorbs decode stalls without losing in-flight reads. A redirect input flushes everything and restarts fetch at a new PC.

## Interface
Parameters:
- ADDR_W, 10: instruction memory word-address width (memory holds 2^ADDR_W words).
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_en  out  1  read request this cycle.
- imem_addr  out  ADDR_W  word address, equal to fetch_pc[ADDR_W+1:2].
- imem_rdata  in  32  read data, valid the cycle after imem_en is high.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0).
- instr_valid  out  1  buffer head holds a valid instruction.
- instr_ready  in  1  decode accepts the head this cycle.
- instr  out  32  head instruction word.
- instr_pc  out  32  byte PC of head instruction.
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- csr  out  12  instr[31:20].

## Operation
- State:
  - fetch_pc (32 bits).
  - inflight (1 bit): a read was issued last cycle.
  - 2-entry FIFO of {word, pc} with count 0..2.
  - inflight_pc: PC of the outstanding read.
- pop = instr_valid & instr_ready.
- Issue rule: imem_en = !rst & !redirect & ((count + inflight - pop) < 2). On issue, inflight_pc <= fetch_pc and fetch_pc <= fetch_pc + 4.
- Response: if inflight was set and no redirect occurred this cycle, push {imem_rdata, inflight_pc} at the end of the cycle.
- Simultaneous push and pop is allowed at any count; count is unchanged.
- Overflow cannot occur by construction. The bench asserts count never exceeds 2.
- Redirect (highest priority):
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - FIFO cleared.
  - inflight cleared; the response arriving this cycle is discarded.
  - No issue this cycle.
  - A pop in the redirect cycle still counts as a transfer; downstream owns that decision.
- Wrap-around: fetch_pc increments modulo 2^32. imem_addr wraps modulo 2^ADDR_W with no special handling.
- Decode fields are pure slices of instr; they are don't-care when instr_valid is 0.
- instr, instr_pc and the fields stay stable while instr_valid & !instr_ready.

## Timing
- Reset values:
  - fetch_pc = RESET_PC; inflight = 0; count = 0.
  - instr_valid = 0, imem_en = 0, instr = 0, instr_pc = 0.
- Reset in mid-operation aborts the outstanding read; its data is dropped.
- After rst deasserts (cycle 0):
  - Cycle 0: imem_en = 1, imem_addr = RESET_PC word.
  - Cycle 1: data returns.
  - Cycle 2: instr_valid = 1.
- Redirect in cycle R:
  - Cycle R+1: first issue at the target.
  - Cycle R+3: instr_valid = 1 with instr_pc = target.
- With instr_ready held high, steady-state throughput is 1 instruction per cycle.
- Stall recovery: when ready rises with count = 2, pops proceed back-to-back. Issue resumes in the same cycle as the first pop, so there are no bubbles.

## Structure
- Shared package riscv_pkg:
  - opcode constants: OP_R 7'b0110011, OP_I 7'b0010011, OP_LUI 7'b0110111, OP_SYSTEM 7'b1110011.
  - NOP 32'h0000_0013.
  - field-slice localparams (bit positions of opcode, funct3, funct7, csr).
  - fetch_entry_t struct {word, pc}.
  The control unit imports the same opcode constants.
- One sub-module, fetch_buf: a 2-entry FIFO of fetch_entry_t with push, pop, flush and count outputs. instr_fetch holds the PC, issue and redirect logic.

## Test plan
- Reset release, RESET_PC=0, memory word n = 32'h0000_0013 + (n<<20), ready=1 -> instr_valid first high at cycle 2 with instr_pc = 0. Then PCs 0, 4, 8, ... on consecutive cycles; opcode = 7'h13.
- Stall: hold ready=0 from cycle 3 for 5 cycles -> count reaches 2 and imem_en goes 0. instr and instr_pc stay stable. On ready=1, PCs continue with no gap and no duplicate.
- Redirect to 32'h0000_0103 while count = 2 and a read is in flight -> the next instr_valid is at R+3 with instr_pc = 32'h100. No stale word is delivered.
- Redirect in the same cycle as a pop -> the popped word is counted once. The flushed entry never appears.
- Wrap: RESET_PC = 32'hFFFF_FFF8, ADDR_W = 10 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. imem_addr goes 3FE, 3FF, 000.
- rst asserted for 1 cycle mid-stream with count = 1 -> the next cycle shows instr_valid = 0 and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch stage and the control unit.
// Holds opcode constants, instruction field positions and the fetch entry type.
package riscv_pkg;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;
    localparam int CSR_LSB    = 20;
    localparam int CSR_MSB    = 31;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {word, pc} pairs sitting between fetch and decode.
// Head is always in r_head so the consumer sees a registered output.
module fetch_buf
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_pushEntry,
    input  logic         i_pop,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_head;
    fetch_entry_t r_tail;
    logic [1:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_pushEntry;
                    end else begin
                        r_tail <= i_pushEntry;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                // Push and pop together: occupancy is unchanged, entries shift forward.
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_pushEntry;
                    end else begin
                        r_head <= i_pushEntry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues synchronous-read memory requests
// and queues returned words for decode; a redirect flushes and restarts fetch.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic [6:0]        opcode,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [11:0]       csr
);

    logic [31:0]  r_fetchPc;
    logic [31:0]  r_inflightPc;
    logic         r_inflight;

    logic         w_pop;
    logic         w_push;
    logic [1:0]   w_count;
    logic [2:0]   w_occupancy;
    fetch_entry_t w_head;
    fetch_entry_t w_pushEntry;

    assign w_pop = instr_valid & instr_ready;

    // Slots already claimed after this cycle's pop; never more than two outstanding.
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign imem_en     = !rst && !redirect && (w_occupancy < 3'd2);
    assign imem_addr   = r_fetchPc[ADDR_W+1:2];

    assign w_push      = r_inflight && !redirect;
    assign w_pushEntry = '{word: imem_rdata, pc: r_inflightPc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchPc    <= RESET_PC & ~32'h3;
            r_inflightPc <= 32'h0;
            r_inflight   <= 1'b0;
        end else if (redirect) begin
            r_fetchPc  <= redirect_pc & ~32'h3;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= imem_en;
            if (imem_en) begin
                r_inflightPc <= r_fetchPc;
                r_fetchPc    <= r_fetchPc + 32'd4;
            end
        end
    end

    fetch_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect),
        .i_push      (w_push),
        .i_pushEntry (w_pushEntry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign instr_valid = (w_count != 2'd0);
    assign instr       = w_head.word;
    assign instr_pc    = w_head.pc;
    assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];
    assign funct3      = instr[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7      = instr[FUNCT7_MSB:FUNCT7_LSB];
    assign csr         = instr[CSR_MSB:CSR_LSB];

endmodule
